picomips_core_param: RTL

//  Parametrised accumulator-based picoMips core: generalised data width, register-file size and program depth.

---
 rtl/picomips_core_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/picomips_core_param.sv
// Accumulator-based picoMips core with a writable program store, a valid/ready input port,
// an output strobe on register 0, a conditional jump and a fixed-point multiply-immediate.
module picomips_core_param #(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 4,
    parameter int PROG_DEPTH = 32,
    parameter int FRAC_BITS  = 2,
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              sw_flag,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy
);

    localparam int R_W = $clog2(NREGS);
    localparam int P_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_JNZ  = 3'd0,
        OP_LIN  = 3'd1,
        OP_RTA  = 3'd2,
        OP_ATR  = 3'd3,
        OP_ADD  = 3'd4,
        OP_ADDI = 3'd5,
        OP_MULI = 3'd6,
        OP_HEI  = 3'd7
    } op_t;

    logic [7:0]        mem_r [PROG_DEPTH];
    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] regs_r [NREGS];
    logic [7:0]        instr_r;
    logic              out_valid_r;

    op_t               op_s;
    logic [4:0]        opnd_s;
    logic [R_W-1:0]    r_s;
    logic [DATA_W-1:0] simm_s;
    logic [DATA_W-1:0] rval_s;
    logic signed [P_W-1:0] acc_ext_s;
    logic signed [P_W-1:0] simm_ext_s;
    logic signed [P_W-1:0] prod_s;
    logic [DATA_W-1:0] muli_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   pc_next_s;
    logic [DATA_W-1:0] acc_next_s;
    logic              complete_s;
    logic              reg_we_s;
    logic [DATA_W-1:0] reg_wdata_s;

    assign op_s     = op_t'(instr_r[7:5]);
    assign opnd_s   = instr_r[4:0];
    assign r_s      = opnd_s[R_W-1:0];
    assign rval_s   = regs_r[r_s];
    assign simm_s   = DATA_W'($signed(opnd_s));
    assign pc_inc_s = pc_r + PC_W'(1'b1);

    // Full-width signed product keeps the sign correct before the fixed-point shift.
    assign acc_ext_s  = P_W'($signed(acc_r));
    assign simm_ext_s = P_W'($signed(simm_s));
    assign prod_s     = acc_ext_s * simm_ext_s;
    assign muli_s     = DATA_W'(prod_s >>> FRAC_BITS);

    // Instruction decode: completion condition and next pc/acc/register values.
    always_comb begin
        complete_s  = 1'b1;
        pc_next_s   = pc_inc_s;
        acc_next_s  = acc_r;
        reg_we_s    = 1'b0;
        reg_wdata_s = acc_r;
        case (op_s)
            OP_JNZ: begin
                if (acc_r != {DATA_W{1'b0}}) begin
                    pc_next_s = opnd_s[PC_W-1:0];
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
            OP_LIN: begin
                complete_s  = in_valid;
                reg_we_s    = 1'b1;
                reg_wdata_s = in_data;
            end
            OP_RTA:  acc_next_s = rval_s;
            OP_ATR:  reg_we_s   = 1'b1;
            OP_ADD:  acc_next_s = acc_r + rval_s;
            OP_ADDI: acc_next_s = acc_r + simm_s;
            OP_MULI: acc_next_s = muli_s;
            OP_HEI:  complete_s = (sw_flag != opnd_s[0]);
            default: complete_s = 1'b1;
        endcase
    end

    // Core sequencer: IDLE/FETCH/EXEC with all architectural state updated on completion.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r     <= ST_IDLE;
            pc_r        <= {PC_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            instr_r     <= 8'h00;
            out_valid_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    instr_r <= mem_r[pc_r];
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (complete_s) begin
                        pc_r  <= pc_next_s;
                        acc_r <= acc_next_s;
                        if (reg_we_s) begin
                            regs_r[r_s] <= reg_wdata_s;
                            out_valid_r <= (r_s == {R_W{1'b0}});
                        end
                        state_r <= run ? ST_FETCH : ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Program store: writable only while idle, deliberately kept across reset.
    always_ff @(posedge Clock) begin
        if (prog_we && (state_r == ST_IDLE)) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    assign in_ready  = (state_r == ST_EXEC) && (op_s == OP_LIN);
    assign out_data  = regs_r[0];
    assign out_valid = out_valid_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
